// File: rtl/sp_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sp_ram_arb_pkg
//  Purpose  : Shared types, constants and helpers for the two-master
//             single-port RAM arbiter.
//  Contents : NUM_MASTERS, mem_req_t (per-master request fields),
//             mem_rsp_t (per-master response fields), in_window() range
//             check helper.
//  Revision : 1.0 - initial release
// ============================================================================
package sp_ram_arb_pkg;

  localparam int NUM_MASTERS = 2;

  // Request fields presented by one master while req_i is high.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

  // Response fields returned to one master the cycle after its grant.
  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } mem_rsp_t;

  // Unsigned window test: base <= addr < limit. The 33-bit compare keeps a
  // window that ends exactly at 2**32 from wrapping to zero.
  function automatic logic in_window(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [32:0] limit
  );
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
  endfunction

endpackage : sp_ram_arb_pkg
`default_nettype wire

// File: rtl/sp_ram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin arbiter. A lone requester is granted
//             immediately; under contention the master that did not win
//             most recently is granted. The last winner is remembered in
//             last_q, which resets to 1 so master 0 wins first contention.
//  Ports    : clk       - clock, rising edge
//             rst_n     - asynchronous active-low reset
//             req_i     - per-master request
//             gnt_o     - one-hot grant (combinational, same cycle)
//             gnt_idx_o - index of the granted master (valid with gnt_any_o)
//             gnt_any_o - some master is granted this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o,
  output logic       gnt_any_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o     = 2'b00;
    gnt_idx_o = 1'b0;
    case (req_i)
      2'b01: begin
        gnt_o     = 2'b01;
        gnt_idx_o = 1'b0;
      end
      2'b10: begin
        gnt_o     = 2'b10;
        gnt_idx_o = 1'b1;
      end
      2'b11: begin
        // Contention: the previous winner yields.
        gnt_idx_o = ~last_q;
        gnt_o     = last_q ? 2'b01 : 2'b10;
      end
      default: begin
        gnt_o     = 2'b00;
        gnt_idx_o = 1'b0;
      end
    endcase
  end

  assign gnt_any_o = |req_i;
  assign last_d    = gnt_any_o ? gnt_idx_o : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sp_ram_arbiter
//  Purpose  : Shares one single-port 32-bit byte-enabled synchronous RAM
//             (1-cycle read latency) between two req/gnt/rvalid masters.
//             Round-robin arbitration, byte-to-word address translation,
//             range checking and response routing to the granted master.
//  Ports    : clk, rst_n          - clock / asynchronous active-low reset
//             req_i[m]            - master m request
//             addr_i[m]           - byte address, bits [1:0] ignored
//             we_i[m], be_i[m]    - write enable / byte enables
//             wdata_i[m]          - write data
//             gnt_o[m]            - grant, combinational with req_i
//             rvalid_o[m]         - response valid, one cycle after grant
//             err_o[m]            - out-of-range flag, valid with rvalid_o
//             rdata_o[m]          - read data (0 for writes and errors)
//             ram_en_o, ram_we_o  - RAM enable / write enable
//             ram_addr_o          - RAM word address
//             ram_be_o, ram_wdata_o - RAM byte enables / write data
//             ram_rdata_i         - RAM read data, registered in the RAM
//  Revision : 1.0 - initial release
// ============================================================================
module sp_ram_arbiter #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          NUM_WORDS  = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_i,
  input  logic [1:0][31:0]      addr_i,
  input  logic [1:0]            we_i,
  input  logic [1:0][3:0]       be_i,
  input  logic [1:0][31:0]      wdata_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [1:0]            err_o,
  output logic [1:0][31:0]      rdata_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  import sp_ram_arb_pkg::*;

  // First byte address past the RAM window, kept at 33 bits so a window
  // touching the top of the address space does not wrap.
  localparam logic [32:0] c_limit = {1'b0, BASE_ADDR} + (33'(NUM_WORDS) * 33'd4);

  // --------------------------------------------------------------------------
  // Request gathering and arbitration
  // --------------------------------------------------------------------------
  mem_req_t w_req [NUM_MASTERS];

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_req
    assign w_req[m] = '{
      addr:  addr_i[m],
      we:    we_i[m],
      be:    be_i[m],
      wdata: wdata_i[m]
    };
  end

  logic w_gnt_idx;
  logic w_gnt_any;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .gnt_idx_o (w_gnt_idx),
    .gnt_any_o (w_gnt_any)
  );

  // --------------------------------------------------------------------------
  // Winner decode, range check and RAM drive
  // --------------------------------------------------------------------------
  mem_req_t    w_win;
  logic [31:0] w_word_addr;
  logic [31:0] w_offset;
  logic        w_in_range;
  logic        w_access;

  assign w_win       = w_req[w_gnt_idx];
  assign w_word_addr = {w_win.addr[31:2], 2'b00};
  assign w_in_range  = in_window(w_word_addr, BASE_ADDR, c_limit);
  assign w_offset    = w_word_addr - BASE_ADDR;
  assign w_access    = w_gnt_any & w_in_range;

  assign ram_en_o    = w_access;
  assign ram_we_o    = w_access & w_win.we;
  assign ram_addr_o  = w_offset[ADDR_WIDTH+1:2];
  assign ram_be_o    = w_win.be;
  assign ram_wdata_o = w_win.wdata;

  // Byte-lane bits and offset bits beyond the RAM depth carry no information.
  logic w_unused;
  assign w_unused = ^{w_win.addr[1:0], w_offset[31:ADDR_WIDTH+2], w_offset[1:0]};

  // --------------------------------------------------------------------------
  // Response pipeline: one stage, aligned with the RAM read latency
  // --------------------------------------------------------------------------
  logic valid_q, valid_d;
  logic owner_q, owner_d;
  logic err_q,   err_d;
  logic rd_q,    rd_d;   // response should carry RAM read data

  always_comb begin
    valid_d = w_gnt_any;
    owner_d = w_gnt_idx;
    err_d   = w_gnt_any & ~w_in_range;
    rd_d    = w_access & ~w_win.we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  mem_rsp_t w_rsp [NUM_MASTERS];

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_rsp
    logic w_mine;
    assign w_mine   = valid_q && (owner_q == 1'(m));
    assign w_rsp[m] = '{
      rvalid: w_mine,
      err:    w_mine && err_q,
      rdata:  (w_mine && rd_q) ? ram_rdata_i : 32'h0
    };
    assign rvalid_o[m] = w_rsp[m].rvalid;
    assign err_o[m]    = w_rsp[m].err;
    assign rdata_o[m]  = w_rsp[m].rdata;
  end

endmodule : sp_ram_arbiter
`default_nettype wire
